// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg: shared defaults and collector state encoding
package payload_engine_pkg;
  localparam int NUM_ENGINES_DEF = 32;
  localparam int PKT_ID_W_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_EMIT} col_state_e;
endpackage

// File: rtl/match_prio_enc.sv
// match_prio_enc: lowest-set-bit index and single-bit flag of a match mask
module match_prio_enc #(
  parameter int W = 32,
  localparam int IW = W > 1 ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          one_hot
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (mask[i]) idx = IW'(i);
  end
  assign one_hot = (mask != '0) && ((mask & (mask - W'(1))) == '0);
endmodule

// File: rtl/engine_match_collector.sv
// engine_match_collector: snapshots engine matches after eop and reports them in ascending order
module engine_match_collector
  import payload_engine_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int PKT_ID_W = PKT_ID_W_DEF,
  parameter int MATCH_LAT = 2,
  localparam int IW = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sod,
  input  logic                   eop,
  input  logic [PKT_ID_W-1:0]    pkt_id,
  input  logic [NUM_ENGINES-1:0] eng_out,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [IW-1:0]          rpt_engine,
  output logic [PKT_ID_W-1:0]    rpt_pkt_id,
  output logic                   rpt_last,
  output logic                   pkt_done,
  output logic [15:0]            drop_cnt
);
  localparam int CW = MATCH_LAT > 0 ? $clog2(MATCH_LAT + 1) : 1;
  col_state_e state, nxt;
  logic [NUM_ENGINES-1:0] mask;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic one_hot, cap, hs, unused_sod;
  assign unused_sod = sod;
  match_prio_enc #(.W(NUM_ENGINES)) u_enc (.mask(mask), .idx(idx), .one_hot(one_hot));
  assign cap = state == S_WAIT && (cnt == '0 || (en && cnt == CW'(1)));
  assign hs = state == S_EMIT && rpt_ready;
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = (en && eop) ? S_WAIT : S_IDLE;
      S_WAIT: nxt = cap ? S_SCAN : S_WAIT;
      S_SCAN: nxt = (mask != '0) ? S_EMIT : S_IDLE;
      S_EMIT: nxt = hs ? (one_hot ? S_IDLE : S_SCAN) : S_EMIT;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    rpt_valid = state == S_EMIT;
    rpt_last = rpt_valid && one_hot;
    rpt_engine = idx;
    pkt_done = (state == S_SCAN && mask == '0) || (hs && one_hot);
  end
  // eop arriving while a packet is in flight is dropped, never queued
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      cnt <= '0;
      rpt_pkt_id <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == S_IDLE && en && eop) begin
        rpt_pkt_id <= pkt_id;
        cnt <= CW'(MATCH_LAT);
      end
      if (state == S_WAIT && en && cnt != '0) cnt <= cnt - CW'(1);
      if (cap) mask <= eng_out;
      if (hs) mask <= mask & ~(NUM_ENGINES'(1) << idx);
      if (state != S_IDLE && en && eop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_engine_match_collector.sv
// tb_engine_match_collector: randomized scoreboard bench with a packet-level reference model
module tb_engine_match_collector;
  localparam int N = 32, IDW = 16, LAT = 2;
  logic clk = 0, rst = 1, en = 0, sod = 0, eop = 0, rpt_ready = 0;
  logic [IDW-1:0] pkt_id = '0;
  logic [N-1:0] eng_out = '0;
  logic rpt_valid, rpt_last, pkt_done;
  logic [4:0] rpt_engine;
  logic [IDW-1:0] rpt_pkt_id;
  logic [15:0] drop_cnt;
  typedef struct {bit done; int eng; int id; bit last;} exp_t;
  exp_t exp_q[$];
  int lat_q[$];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_drop = 0;

  engine_match_collector #(.NUM_ENGINES(N), .PKT_ID_W(IDW), .MATCH_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .sod(sod), .eop(eop), .pkt_id(pkt_id), .eng_out(eng_out),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_engine(rpt_engine), .rpt_pkt_id(rpt_pkt_id),
    .rpt_last(rpt_last), .pkt_done(pkt_done), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: nothing expected at cycle %0d", nm, cyc);
  endtask

  bit first = 1, pv = 0, p_last;
  int p_eng, p_id;
  always @(negedge clk) begin
    if (rst) begin
      first = 1;
      pv = 0;
    end else begin
      if ((rpt_valid || pkt_done) && first) begin
        if (lat_q.size() == 0) flag("unexpected_output");
        else chk("first_output_cycle", cyc, lat_q.pop_front());
        first = 0;
      end
      if (rpt_valid) begin
        if (pv) begin
          chk("hold_engine", rpt_engine, p_eng);
          chk("hold_pkt_id", rpt_pkt_id, p_id);
          chk("hold_last", rpt_last, p_last);
        end
        if (exp_q.size() == 0 || exp_q[0].done) flag("unexpected_report");
        else begin
          chk("rpt_engine", rpt_engine, exp_q[0].eng);
          chk("rpt_pkt_id", rpt_pkt_id, exp_q[0].id);
          chk("rpt_last", rpt_last, exp_q[0].last);
          if (rpt_ready) exp_q.delete(0);
        end
        pv = !rpt_ready;
        p_eng = rpt_engine;
        p_id = rpt_pkt_id;
        p_last = rpt_last;
      end else pv = 0;
      if (pkt_done) begin
        if (exp_q.size() == 0 || !exp_q[0].done) flag("unexpected_pkt_done");
        else exp_q.delete(0);
        done_cnt++;
        first = 1;
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] m, input int id);
    int hi = -1;
    for (int i = 0; i < N; i++) if (m[i]) hi = i;
    for (int i = 0; i < N; i++) if (m[i]) exp_q.push_back('{0, i, id, i == hi});
    exp_q.push_back('{1, 0, 0, 0});
  endtask

  // Capture happens on the LAT-th en cycle after eop; eng_out is junk on every other cycle.
  task automatic run_pkt(input logic [N-1:0] m, input logic [IDW-1:0] id, input int rdy_pct, input int drop_pct);
    int ens = 0, guard = 0, start = done_cnt;
    bit captured = 0;
    push_exp(m, id);
    en = 1; eop = 1; pkt_id = id; eng_out = $urandom; sod = $urandom;
    rpt_ready = $urandom_range(0, 99) < rdy_pct;
    @(posedge clk); #1;
    while (done_cnt == start && guard < 2000) begin
      en = captured ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) != 0);
      eop = $urandom_range(0, 99) < drop_pct;
      if (en && eop && exp_drop < 65535) exp_drop++;
      pkt_id = $urandom; sod = $urandom; eng_out = $urandom;
      rpt_ready = $urandom_range(0, 99) < rdy_pct;
      if (!captured && en) ens++;
      if (!captured && ens == LAT) begin
        eng_out = m;
        captured = 1;
        lat_q.push_back(cyc + (m != '0 ? 2 : 1));
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) flag("packet_timeout");
    en = 0; eop = 0;
    chk("drop_cnt", drop_cnt, exp_drop);
    repeat ($urandom_range(0, 2)) begin
      en = $urandom; eop = !en && $urandom_range(0, 1); sod = $urandom;
      @(posedge clk); #1;
    end
    en = 0; eop = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [N-1:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", rpt_valid, 0);
    chk("reset_done", pkt_done, 0);
    chk("reset_drop", drop_cnt, 0);
    chk("reset_engine", rpt_engine, 0);
    rst = 0;
    @(posedge clk); #1;
    run_pkt(32'h0000_0005, 16'h0042, 100, 0);
    run_pkt(32'h0000_0000, 16'h0007, 100, 0);
    run_pkt(32'h8000_0001, 16'h0031, 20, 0);
    run_pkt(32'h0000_0006, 16'h0001, 40, 30);
    run_pkt(32'hFFFF_FFFF, 16'hBEEF, 60, 10);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = N'(1) << $urandom_range(0, N - 1);
        default: m = $urandom;
      endcase
      run_pkt(m, IDW'($urandom), $urandom_range(20, 100), $urandom_range(0, 25));
    end
    // reset while reports are pending abandons them; rst outranks a same-cycle eop
    push_exp(32'h7, 16'h00AA);
    lat_q.push_back(cyc + LAT + 2);
    en = 1; eop = 1; pkt_id = 16'h00AA; eng_out = 32'h7; rpt_ready = 0;
    @(posedge clk); #1;
    eop = 0;
    g = 0;
    while (!rpt_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 20) flag("reset_test_timeout");
    @(posedge clk); #1;
    rst = 1; eop = 1;
    exp_q.delete(); lat_q.delete(); exp_drop = 0;
    @(posedge clk); #1;
    rst = 0; eop = 0; en = 0;
    chk("rst_mid_emit_valid", rpt_valid, 0);
    chk("rst_mid_emit_drop", drop_cnt, 0);
    chk("rst_mid_emit_last", rpt_last, 0);
    chk("rst_mid_emit_done", pkt_done, 0);
    chk("rst_mid_emit_pkt_id", rpt_pkt_id, 0);
    chk("rst_mid_emit_engine", rpt_engine, 0);
    @(posedge clk); #1;
    run_pkt(32'h0000_0300, 16'h0055, 60, 10);
    repeat (4) @(posedge clk);
    #1;
    chk("leftover_reports", exp_q.size(), 0);
    chk("leftover_latency", lat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/engine_match_collector.md
ENGINE_MATCH_COLLECTOR -- requirements
Module: engine_match_collector

Interface
REQ-001 Parameter NUM_ENGINES, default 32, number of engine match outputs collected.
REQ-002 Parameter PKT_ID_W, default 16, width of packet identifier.
REQ-003 Parameter MATCH_LAT, default 2, enabled-cycle latency from last payload character to settled engine output.
REQ-004 One clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  character-strobe shared with engines; qualifies eop and latency countdown.
REQ-008 sod  input  1  start-of-data pulse shared with engines (engine clear); informational only here.
REQ-009 eop  input  1  last payload character of packet, valid only when en=1.
REQ-010 pkt_id  input  PKT_ID_W  packet identifier, sampled with eop.
REQ-011 eng_out  input  NUM_ENGINES  sticky engine match outputs, bit i = engine i.
REQ-012 rpt_valid  output  1  match report valid.
REQ-013 rpt_ready  input  1  downstream accepts report.
REQ-014 rpt_engine  output  clog2(NUM_ENGINES)  index of matched engine.
REQ-015 rpt_pkt_id  output  PKT_ID_W  packet identifier of the report.
REQ-016 rpt_last  output  1  final report for this packet.
REQ-017 pkt_done  output  1  one-cycle pulse when a packet's reporting completes (including zero matches).
REQ-018 drop_cnt  output  16  saturating count of packets dropped by overflow.

Function
REQ-019 States: IDLE, WAIT, SCAN, EMIT.
REQ-020 IDLE: en&eop -> latch pkt_id, load countdown with MATCH_LAT, go WAIT.
REQ-021 WAIT: countdown decrements only on en=1 cycles; at zero capture eng_out into snapshot mask, go SCAN.
REQ-022 SCAN (one cycle): mask nonzero -> go EMIT with lowest set bit index; mask zero -> pulse pkt_done, go IDLE.
REQ-023 EMIT: rpt_valid=1; rpt_engine, rpt_pkt_id, rpt_last stable until rpt_valid&rpt_ready.
REQ-024 rpt_last=1 exactly when the emitted bit is the only set bit of the mask.
REQ-025 On handshake: clear emitted bit; if rpt_last, pulse pkt_done same cycle and go IDLE, else go SCAN.
REQ-026 Reports per packet emitted in strictly ascending engine index; each set bit reported exactly once.
REQ-027 en&eop while not IDLE -> packet dropped, in-flight packet unaffected, drop_cnt increments, saturating at 16'hFFFF.
REQ-028 sod at any time does not alter snapshot, state, or outputs.
REQ-029 eng_out changes after capture do not affect current reports.
REQ-030 Minimum latency eop -> rpt_valid: MATCH_LAT en-cycles + 2 clocks.

Reset
REQ-031 rst=1 on a rising edge -> state IDLE, snapshot 0, countdown 0, rpt_valid 0, rpt_last 0, pkt_done 0, rpt_engine 0, rpt_pkt_id 0, drop_cnt 0.
REQ-032 Reset mid-EMIT abandons remaining reports with no pkt_done and no drop_cnt change.
REQ-033 rst has priority over all other inputs in the same cycle.

Structure
REQ-034 Shared package payload_engine_pkg holds NUM_ENGINES default, PKT_ID_W default, and the collector state enumeration.
REQ-035 Lowest-set-bit search is a separate sub-module match_prio_enc (mask in; index and one-hot-remaining flag out; combinational).

Verification
REQ-036 MATCH_LAT=2, eop with pkt_id=0x0042, eng_out=0x00000005 settles, rpt_ready=1 -> reports (0,0x0042,last=0), (2,0x0042,last=1), pkt_done with second handshake.
REQ-037 eng_out=0 at capture -> no rpt_valid, single pkt_done pulse one cycle after capture.
REQ-038 eng_out=0x80000001, rpt_ready low for 5 cycles -> rpt_valid held, engine 0 stable; then engine 0, engine 31 last.
REQ-039 Second eop during EMIT of pkt 0x0001 -> drop_cnt 0->1, pkt 0x0001 reports complete unchanged.
REQ-040 en toggling 1-0-1 during WAIT -> capture delayed until second en=1 cycle.
REQ-041 rst asserted mid-EMIT with two bits pending -> next cycle rpt_valid=0, state IDLE, drop_cnt 0, new eop processed normally.
